// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction fetch stage with PC register and IF/ID pipeline register
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_flushed counters.
module fetch_stage #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic                   jump,
  input  logic [PC_WIDTH-1:0]    jump_target,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [PC_WIDTH-1:0]    if_id_pc_plus4,
  output logic                   if_id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_flushed
`endif
);

  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] branch_aligned;
  logic [PC_WIDTH-1:0] jump_aligned;
  logic [PC_WIDTH-1:0] reset_aligned;

  // Targets are forced word-aligned so pc[1:0] can never become nonzero.
  assign pc_plus4       = pc + {{(PC_WIDTH-3){1'b0}}, 3'b100};
  assign branch_aligned = {branch_target[PC_WIDTH-1:2], 2'b00};
  assign jump_aligned   = {jump_target[PC_WIDTH-1:2], 2'b00};
  assign reset_aligned  = {RESET_PC[PC_WIDTH-1:2], 2'b00};
  assign imem_addr      = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc             <= reset_aligned;
      if_id_instr    <= '0;
      if_id_pc_plus4 <= '0;
      if_id_valid    <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
      perf_fetched   <= '0;
      perf_flushed   <= '0;
`endif
    end else if (enable) begin
      if (branch_taken) begin
        pc             <= branch_aligned;
        if_id_instr    <= '0;
        if_id_pc_plus4 <= '0;
        if_id_valid    <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
        perf_flushed   <= perf_flushed + 32'd1;
`endif
      end else if (stall) begin
        // Hold: a jump sitting in ID is the stalled instruction itself.
        pc             <= pc;
      end else if (jump) begin
        pc             <= jump_aligned;
        if_id_instr    <= '0;
        if_id_pc_plus4 <= '0;
        if_id_valid    <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
        perf_flushed   <= perf_flushed + 32'd1;
`endif
      end else begin
        pc             <= pc_plus4;
        if_id_instr    <= imem_rdata;
        if_id_pc_plus4 <= pc_plus4;
        if_id_valid    <= 1'b1;
`ifdef FETCH_PERF_CNT_EN
        perf_fetched   <= perf_fetched + 32'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
// Exercises counters when FETCH_PERF_CNT_EN is defined.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instruction memory model: the word at byte address A holds A/4.
  assign imem_rdata = {2'b00, imem_addr[31:2]};

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jump           (jump),
    .jump_target    (jump_target),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [31:0] addr,
                              input logic [31:0] instr, input logic [31:0] pc4,
                              input logic valid);
    chk({tag, ".addr"},  imem_addr,      addr);
    chk({tag, ".instr"}, if_id_instr,    instr);
    chk({tag, ".pc4"},   if_id_pc_plus4, pc4);
    chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0;

    // Reset must act even with enable low.
    step();
    expect_state("reset", 32'h0, 32'h0, 32'h0, 1'b0);

    rst = 1'b0; enable = 1'b1;
    step(); expect_state("fetch0", 32'h4,  32'd0, 32'h4,  1'b1);
    step(); expect_state("fetch1", 32'h8,  32'd1, 32'h8,  1'b1);
    step(); expect_state("fetch2", 32'hC,  32'd2, 32'hC,  1'b1);
    step(); expect_state("fetch3", 32'h10, 32'd3, 32'h10, 1'b1);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); expect_state("stall", 32'h10, 32'd3, 32'h10, 1'b1);
    end
    stall = 1'b0;
    step(); expect_state("unstall", 32'h14, 32'd4, 32'h14, 1'b1);

    enable = 1'b0; jump = 1'b1; jump_target = 32'h100;
    step(); expect_state("disabled", 32'h14, 32'd4, 32'h14, 1'b1);
    enable = 1'b1; jump = 1'b0;

    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
    step(); expect_state("branch", 32'h40, 32'h0, 32'h0, 1'b0);
    stall = 1'b0; branch_taken = 1'b0;
    step(); expect_state("branch_tgt", 32'h44, 32'h10, 32'h44, 1'b1);

    jump = 1'b1; jump_target = 32'h83;
    step(); expect_state("jump", 32'h80, 32'h0, 32'h0, 1'b0);
    jump = 1'b0;
    step(); expect_state("jump_tgt", 32'h84, 32'h20, 32'h84, 1'b1);

    jump = 1'b1; jump_target = 32'h200; stall = 1'b1;
    step(); expect_state("jump_stalled", 32'h84, 32'h20, 32'h84, 1'b1);
    stall = 1'b0;

    jump_target = 32'hFFFF_FFFC;
    step(); expect_state("jump_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    jump = 1'b0;
    step(); expect_state("wrap", 32'h0, 32'h3FFF_FFFF, 32'h0, 1'b1);
    step(); expect_state("post_wrap", 32'h4, 32'h0, 32'h4, 1'b1);

    rst = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
    step(); expect_state("mid_reset", 32'h0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0; branch_taken = 1'b0;

    // 10 fetches and 2 redirects from a fresh reset.
    for (int i = 0; i < 5; i++) step();
    jump = 1'b1; jump_target = 32'h300;
    step();
    jump = 1'b0;
    for (int i = 0; i < 5; i++) step();
    expect_state("run_a", 32'h314, 32'hC4, 32'h314, 1'b1);
    branch_taken = 1'b1; branch_target = 32'h500;
    step();
    branch_taken = 1'b0;
    expect_state("run_b", 32'h500, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, 32'd10);
    chk("perf_flushed", perf_flushed, 32'd2);
    enable = 1'b0;
    step();
    chk("perf_hold", perf_fetched, 32'd10);
    enable = 1'b1; rst = 1'b1;
    step();
    chk("perf_rst_f", perf_fetched, 32'd0);
    chk("perf_rst_b", perf_flushed, 32'd0);
    rst = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage and IF/ID pipeline register of the pipelined MIPS core. Holds the program counter, drives the instruction-memory address, and registers the fetched word and PC+4 into the IF/ID register. The main decoder reads its opcode from `if_id_instr[31:26]`. The stage also handles hazard stalls, taken-branch and jump redirects, and bubble insertion on flush.

## Interface
- `PC_WIDTH`, default 32: PC and target width.
- `INSTR_WIDTH`, default 32: instruction word width.
- `RESET_PC`, default 0: PC value loaded on reset; must be word-aligned.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `enable`  in  1  global run enable; 0 freezes all state.
- `stall`  in  1  hazard-unit hold request for the instruction in ID.
- `branch_taken`  in  1  resolved taken `beq` from EX.
- `branch_target`  in  PC_WIDTH  branch destination.
- `jump`  in  1  jump decoded in ID.
- `jump_target`  in  PC_WIDTH  jump destination.
- `imem_addr`  out  PC_WIDTH  instruction-memory byte address; equals current PC.
- `imem_rdata`  in  INSTR_WIDTH  combinational instruction-memory read data.
- `if_id_instr`  out  INSTR_WIDTH  registered instruction to decode.
- `if_id_pc_plus4`  out  PC_WIDTH  registered PC+4 of that instruction.
- `if_id_valid`  out  1  1 = real instruction, 0 = bubble.

## Operation
- State consists of the `pc` register, the IF/ID register (`instr`, `pc_plus4`, `valid`), and the optional counters.
- `imem_addr = pc`. Bits [1:0] of `pc` are always 0. Bits [1:0] of both targets are masked to 0 before loading.
- `pc + 4` is computed at PC_WIDTH and wraps modulo 2^PC_WIDTH. `0xFFFFFFFC` goes to `0x00000000`.
- On a clock edge with `enable` = 1, evaluate in this priority order (highest first):
  1. `rst`: pc ← RESET_PC; IF/ID ← {0, 0, 0}.
  2. `branch_taken`: pc ← `branch_target`; IF/ID ← bubble. The branch is older than anything in ID/IF, so it overrides `stall`.
  3. `stall`: pc and IF/ID hold. A jump in ID is the stalled instruction, so `jump` is ignored while `stall` = 1.
  4. `jump`: pc ← `jump_target`; IF/ID ← bubble.
  5. Otherwise: pc ← pc+4; IF/ID ← {`imem_rdata`, pc+4, 1}.
- `enable` = 0 with `rst` = 0: all state holds regardless of other inputs. `rst` acts even when `enable` = 0.
- A bubble is `if_id_instr` = 32'h0000_0000 (sll $0, opcode 0, harmless R-type), `if_id_pc_plus4` = 0, `if_id_valid` = 0.
- No combinational path from any input to any output except `imem_rdata` → nothing. All outputs are registered; `imem_addr` comes directly from the pc register.

## Timing
- Reset values: `imem_addr` = RESET_PC, `if_id_instr` = 0, `if_id_pc_plus4` = 0, `if_id_valid` = 0.
- The first valid instruction appears in IF/ID one edge after the first edge with `rst` = 0 and `enable` = 1.
- Fetch latency: the word at address A appears in IF/ID on the edge that ends the cycle in which `imem_addr` = A.
- Redirect penalty:
  - `branch_taken` sampled at edge N: `imem_addr` = target during cycle N+1, and the target instruction is valid in IF/ID after edge N+1. One bubble comes from this stage; killing ID is handled downstream.
  - `jump` at edge N: same as branch, giving exactly one bubble.
- Stall lasting k cycles: IF/ID and `imem_addr` are held for exactly k edges. Fetch then resumes at pc+4.
- `rst` asserted mid-operation: takes effect at the next edge and overrides all other inputs.

## Configuration
- `FETCH_PERF_CNT_EN` defined: adds two 32-bit outputs.
  - `perf_fetched`: counts edges that load a valid instruction into IF/ID.
  - `perf_flushed`: counts edges that insert a redirect bubble.
  - Both reset to 0 on `rst`, hold when `enable` = 0, and wrap at 2^32.
- Not defined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset then run with RESET_PC = 0 and imem[i] = i: IF/ID gets {0, 4, 1}, then {1, 8, 1}, then {2, 12, 1} on consecutive edges.
- `stall` = 1 for 3 cycles with pc = 0x10: `imem_addr` stays 0x10 and IF/ID is unchanged for 3 edges. After release, `imem_addr` = 0x14.
- `branch_taken` = 1 with target 0x40 during a stall: next `imem_addr` = 0x40 and `if_id_valid` = 0. The following edge gives {imem[0x40], 0x44, 1}.
- `jump` = 1 with target 0x83 and `stall` = 0: `imem_addr` = 0x80 and one bubble is inserted. Repeat with `stall` = 1: the jump is ignored and pc holds.
- pc = 0xFFFFFFFC, no redirect: next `imem_addr` = 0x0 and `if_id_pc_plus4` = 0x0. Then assert `rst` mid-stream: all outputs return to their reset values at that edge.
- With `FETCH_PERF_CNT_EN`: 10 normal fetches plus 2 redirects give `perf_fetched` = 10 and `perf_flushed` = 2.
